pipe_hazard_ctrl: RTL and testbench

- Control-side counterpart of the pipeline registers. It generates the per-stage write-enable and flush (bubble) controls that the IF/ID, ID/EX and EX/MEM registers consume.
- It detects load-use hazards, branch-taken squashes and multi-cycle mul/div occupancy, and tracks the mul/div unit with an internal FSM and counter.
- It sits between the decode/execute stages and the pipeline registers of the 5-stage CPU.

---
 rtl/pipe_pkg.sv | 6 +
 rtl/md_tracker.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 72 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default sizes for the pipeline hazard controller
package pipe_pkg;
  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} md_state_e;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int MULDIV_CYCLES_DEF = 32;
endpackage

// File: rtl/md_tracker.sv
// md_tracker: mul/div occupancy FSM with a cycle down-counter and done pulse
module md_tracker
  import pipe_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_muldiv_start,
  input  logic             accept,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] md_cnt
);
  md_state_e state, state_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic take, counting;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      md_cnt <= '0;
    end else begin
      state <= state_nx;
      md_cnt <= cnt_nx;
    end
  end
  always_comb begin
    take = ex_muldiv_start && accept;
    counting = state == MD_BUSY && md_cnt != '0;
    state_nx = (take || counting) ? MD_BUSY : RUN;
    cnt_nx = take ? CNT_W'(MULDIV_CYCLES - 1) : counting ? md_cnt - 1'b1 : '0;
    md_busy = !rst && state == MD_BUSY;
    md_done = md_busy && md_cnt == '0;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush control for load-use, branch and mul/div hazards
// Optional performance counters enabled by PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_reads_hilo,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_muldiv_start,
  input  logic                  ex_branch_taken,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);
  logic load_use, md_struct, hilo_haz, br, stall;
  logic [CNT_W-1:0] md_cnt;
  md_tracker #(.MULDIV_CYCLES(MULDIV_CYCLES), .CNT_W(CNT_W)) u_md (
    .clk(clk),
    .rst(rst),
    .ex_muldiv_start(ex_muldiv_start),
    .accept(!ex_branch_taken && !md_struct),
    .md_busy(md_busy),
    .md_done(md_done),
    .md_cnt(md_cnt)
  );
  // A taken branch overrides every stall; md_struct freezes ID/EX instead of bubbling it.
  always_comb begin
    load_use = ex_mem_read && ex_rd != '0 &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    md_struct = ex_muldiv_start && md_busy && md_cnt != '0;
    hilo_haz = id_reads_hilo && (md_busy || ex_muldiv_start);
    br = !rst && ex_branch_taken;
    stall = !rst && !ex_branch_taken && (md_struct || hilo_haz || load_use);
    pc_en = !rst && !stall;
    ifid_en = pc_en;
    ifid_flush = br;
    idex_en = !rst && !(stall && md_struct);
    idex_flush = br || (stall && !md_struct);
    exmem_flush = stall && md_struct;
  end
`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_en) stall_cycles <= stall_cycles + 1'b1;
      if (br) flush_count <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl with MULDIV_CYCLES=4
module tb_pipe_hazard_ctrl;
  localparam logic [7:0] NORM = 8'b1101_0000;
  localparam logic [7:0] LU   = 8'b0001_1000;
  localparam logic [7:0] BR   = 8'b1111_1000;
  localparam logic [7:0] MDS  = 8'b0000_0100;
  localparam logic [7:0] B    = 8'b0000_0010;
  localparam logic [7:0] D    = 8'b0000_0001;
  localparam logic [7:0] Z    = 8'b0000_0000;
  localparam logic H = 1'b1, L = 1'b0;
`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, id_uses_rs, id_uses_rt, id_reads_hilo, ex_mem_read, ex_muldiv_start, ex_branch_taken;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, md_busy, md_done;
  logic [31:0] stall_cycles, flush_count;
  logic [7:0] outs;
  logic [7:0] sb[$];
  logic [31:0] exp_stall = 0, exp_flush = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, md_busy, md_done};

  pipe_hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_muldiv_start(ex_muldiv_start),
    .ex_branch_taken(ex_branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic drive(input logic r, br, st, hl, mr, ur, ut, input logic [4:0] rd, rs, rt,
                       input logic [7:0] e);
    @(negedge clk);
    rst = r; ex_branch_taken = br; ex_muldiv_start = st; id_reads_hilo = hl;
    ex_mem_read = mr; id_uses_rs = ur; id_uses_rt = ut; ex_rd = rd; id_rs = rs; id_rt = rt;
    sb.push_back(e);
    if (r) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!e[7]) exp_stall++;
      if (br) exp_flush++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] e[3] = '{Z, Z, NORM};
    logic [7:0] want;
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, i == 1, i == 1, i == 1, i == 0, i == 0, L,
            i == 0 ? 5'd8 : 5'd0, i == 0 ? 5'd8 : 5'd0, 5'd0, e[i]);
      #2; want = sb.pop_front(); checks++;
      if (outs !== want) begin errors++; $display("FAIL reset[%0d] got %b want %b", i, outs, want); end
    end
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles); end
    checks++;
    if (flush_count !== 32'd0) begin errors++; $display("FAIL reset_flush_count got %0d want 0", flush_count); end
  endtask

  task automatic test_load_use();
    logic [4:0] rd[5] = '{5'd8, 5'd0, 5'd8, 5'd8, 5'd8};
    logic [4:0] rs[5] = '{5'd8, 5'd0, 5'd3, 5'd8, 5'd8};
    logic [4:0] rt[5] = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd8};
    logic ur[5] = '{H, H, L, L, H};
    logic ut[5] = '{L, L, H, L, L};
    logic mr[5] = '{H, H, H, H, L};
    logic [7:0] e[5] = '{LU, NORM, LU, NORM, NORM};
    logic [7:0] want;
    for (int i = 0; i < 5; i++) begin
      drive(L, L, L, L, mr[i], ur[i], ut[i], rd[i], rs[i], rt[i], e[i]);
      #2; want = sb.pop_front(); checks++;
      if (outs !== want) begin errors++; $display("FAIL load_use[%0d] got %b want %b", i, outs, want); end
    end
  endtask

  task automatic test_branch();
    logic [7:0] e[4] = '{BR, BR, BR, NORM};
    logic [7:0] want;
    for (int i = 0; i < 4; i++) begin
      drive(L, i < 3, i == 2, L, i == 0, i == 0, L,
            i == 0 ? 5'd8 : 5'd0, i == 0 ? 5'd8 : 5'd0, 5'd0, e[i]);
      #2; want = sb.pop_front(); checks++;
      if (outs !== want) begin errors++; $display("FAIL branch[%0d] got %b want %b", i, outs, want); end
    end
  endtask

  task automatic test_muldiv();
    logic [7:0] e[6] = '{NORM, NORM | B, NORM | B, NORM | B, NORM | B | D, NORM};
    logic [7:0] want;
    for (int i = 0; i < 6; i++) begin
      drive(L, L, i == 0, L, L, L, L, 5'd0, 5'd0, 5'd0, e[i]);
      #2; want = sb.pop_front(); checks++;
      if (outs !== want) begin errors++; $display("FAIL muldiv[%0d] got %b want %b", i, outs, want); end
    end
  endtask

  task automatic test_struct();
    logic [7:0] e[10] = '{NORM, NORM | B, MDS | B, MDS | B, NORM | B | D,
                          NORM | B, NORM | B, NORM | B, NORM | B | D, NORM};
    logic [7:0] want;
    for (int i = 0; i < 10; i++) begin
      drive(L, L, i == 0 || (i >= 2 && i <= 4), L, L, L, L, 5'd0, 5'd0, 5'd0, e[i]);
      #2; want = sb.pop_front(); checks++;
      if (outs !== want) begin errors++; $display("FAIL struct[%0d] got %b want %b", i, outs, want); end
    end
  endtask

  task automatic test_hilo();
    logic [7:0] e[6] = '{LU, LU | B, LU | B, LU | B, LU | B | D, NORM};
    logic [7:0] want;
    for (int i = 0; i < 6; i++) begin
      drive(L, L, i == 0, H, L, L, L, 5'd0, 5'd0, 5'd0, e[i]);
      #2; want = sb.pop_front(); checks++;
      if (outs !== want) begin errors++; $display("FAIL hilo[%0d] got %b want %b", i, outs, want); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e[5] = '{NORM, NORM | B, Z, NORM, NORM};
    logic [7:0] want;
    for (int i = 0; i < 5; i++) begin
      drive(i == 2, L, i == 0, L, L, L, L, 5'd0, 5'd0, 5'd0, e[i]);
      #2; want = sb.pop_front(); checks++;
      if (outs !== want) begin errors++; $display("FAIL reset_mid[%0d] got %b want %b", i, outs, want); end
      if (i == 3) begin
        checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_mid_stall got %0d want 0", stall_cycles); end
        checks++;
        if (flush_count !== 32'd0) begin errors++; $display("FAIL reset_mid_flush got %0d want 0", flush_count); end
      end
    end
  endtask

  task automatic test_perf();
    logic [7:0] e[5] = '{BR, LU, LU, BR, NORM};
    logic [7:0] want;
    for (int i = 0; i < 5; i++) begin
      drive(L, i == 0 || i == 3, L, L, i == 1 || i == 2, i == 1 || i == 2, L,
            5'd9, 5'd9, 5'd0, e[i]);
      #2; want = sb.pop_front(); checks++;
      if (outs !== want) begin errors++; $display("FAIL perf_seq[%0d] got %b want %b", i, outs, want); end
    end
    @(negedge clk);
    checks++;
    if (stall_cycles !== (PERF ? exp_stall : 32'd0)) begin
      errors++; $display("FAIL perf_stall_cycles got %0d want %0d", stall_cycles, PERF ? exp_stall : 32'd0);
    end
    checks++;
    if (flush_count !== (PERF ? exp_flush : 32'd0)) begin
      errors++; $display("FAIL perf_flush_count got %0d want %0d", flush_count, PERF ? exp_flush : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_reads_hilo = 1'b0; ex_mem_read = 1'b0; ex_muldiv_start = 1'b0; ex_branch_taken = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_struct();
    test_hilo();
    test_reset_mid();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
